matrix_frame_buffer: RTL

- Parametrised, double-buffered LED-matrix row source for the pong display path.
- Stores a ROWS x WIDTH frame written by game logic into a back bank.
- Scans the front bank one row at a time at a divided rate, and presents the registered row pattern plus row index to the matrix driver.
- Provides built-in test patterns selectable per frame, and tear-free bank swap at frame boundary.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_scan_timer.sv | 37 +++
 rtl/matrix_frame_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix frame buffer.
// Pattern modes and default geometry.
package matrix_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ROWS  = 16;

  typedef enum logic [1:0] {
    MODE_BUF   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_PIX   = 2'd3
  } mode_t;

endpackage

// File: rtl/matrix_scan_timer.sv
// Row scan timer: clock divider plus row counter.
// tick marks the last divider cycle; wrap is a tick on the last row.
module matrix_scan_timer
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int ROWS     = DEF_ROWS,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic          wrap,
  output logic [RW-1:0] row_idx,
  output logic [RW-1:0] row_next
);

  logic [DW-1:0] div;
  logic          last_row;

  assign tick     = (div == DW'(SCAN_DIV - 1));
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign wrap     = tick && last_row;
  assign row_next = last_row ? '0 : row_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      row_idx <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) row_idx <= row_next;
    end
  end

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered LED-matrix row source with test patterns.
// Game logic writes the back bank; front bank swaps only at frame wrap.
module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ROWS     = DEF_ROWS,
  parameter int SCAN_DIV = 1024,
  parameter int PIX_ROW  = 0,
  parameter int PIX_COL  = 12,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  input  logic [1:0]       pattern_mode,
  output logic [RW-1:0]    row_idx,
  output logic [WIDTH-1:0] row_data,
  output logic             frame_start
);

  logic [WIDTH-1:0] bank0 [ROWS];
  logic [WIDTH-1:0] bank1 [ROWS];

  logic             front;
  logic             pending;
  mode_t            mode_q;
  logic             tick;
  logic             wrap;
  logic [RW-1:0]    row_next;
  logic             do_swap;
  logic             wr_ok;
  logic [RW-1:0]    sel_row;
  logic             sel_front;
  mode_t            sel_mode;
  logic [WIDTH-1:0] src;

  matrix_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .ROWS     (ROWS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .wrap     (wrap),
    .row_idx  (row_idx),
    .row_next (row_next)
  );

  assign do_swap = wrap && (pending || swap_req);
  assign wr_ok   = wr_en && ({1'b0, wr_row} < (RW + 1)'(ROWS));

  // On a tick, look ahead to the next row as the new frame will see it.
  always_comb begin
    sel_row   = tick ? row_next : row_idx;
    sel_front = front ^ do_swap;
    sel_mode  = wrap ? mode_t'(pattern_mode) : mode_q;
    src       = '0;
    unique case (sel_mode)
      MODE_BUF:   src = sel_front ? bank1[sel_row] : bank0[sel_row];
      MODE_ALL:   src = '1;
      MODE_CHECK: begin
        for (int c = 0; c < WIDTH; c++) src[c] = (sel_row[0] == c[0]);
      end
      MODE_PIX:   begin
        if (sel_row == RW'(PIX_ROW)) src[PIX_COL] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front       <= 1'b0;
      pending     <= 1'b0;
      mode_q      <= MODE_BUF;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      row_data    <= '0;
    end else begin
      swap_ack    <= do_swap;
      frame_start <= wrap;
      row_data    <= src;
      if (do_swap) front <= ~front;
      if (wrap) begin
        mode_q  <= mode_t'(pattern_mode);
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Back bank is the one not in front before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) bank0[i] <= '0;
    end else if (wr_ok && front) begin
      bank0[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) bank1[i] <= '0;
    end else if (wr_ok && !front) begin
      bank1[wr_row] <= wr_data;
    end
  end

endmodule
